// File: rtl/random_lfsr_stream_pkg.sv
// Shared FSM encoding, maximal-length Galois tap masks and the LFSR step function
// used by random_lfsr_stream and its lfsr_core.
package random_pkg;

    typedef logic [0:0] rng_state_t;

    localparam rng_state_t StFill  = 1'b0;
    localparam rng_state_t StValid = 1'b1;

    // Right-shifting Galois masks for maximal-length sequences
    localparam logic [7:0]  Taps8  = 8'hB8;
    localparam logic [15:0] Taps16 = 16'hB400;
    localparam logic [31:0] Taps32 = 32'h8020_0003;
    localparam logic [63:0] Taps64 = 64'hD800_0000_0000_0000;

    function automatic logic [63:0] lfsr_step(input logic [63:0] s, input logic [63:0] taps);
        return (s >> 1) ^ (s[0] ? taps : 64'h0);
    endfunction

endpackage

// File: rtl/random_lfsr_stream_if.sv
// Valid/ready word stream between the random source (master) and its consumer (slave).
interface random_lfsr_stream_if #(
    parameter int unsigned WIDTH = 16
) ();

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );

endinterface

// File: rtl/random_lfsr_stream_lfsr_core.sv
// LFSR state register with load mux and advance enable; exposes the state one step ahead
// so the owner can capture the word it is about to become.
module lfsr_core #(
    parameter int unsigned      WIDTH        = 16,
    parameter logic [WIDTH-1:0] TAPS         = 16'hB400,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             adv,
    output logic [WIDTH-1:0] step_val
);
    import random_pkg::*;

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;

    assign step_val = WIDTH'(lfsr_step(64'(state_q), 64'(TAPS)));

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = load_val;
        end else if (adv) begin
            state_d = step_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DEFAULT_SEED;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/random_lfsr_stream.sv
// Galois-LFSR pseudo-random word source with reseed, zero-seed protection and STEPS_PER_OUT
// shifts per word. Define RNG_PERIOD_FLAG_EN to add the period_wrap full-period flag.
module random_lfsr_stream #(
    parameter int unsigned      WIDTH         = 16,
    parameter logic [WIDTH-1:0] TAPS          = 16'hB400,
    parameter logic [WIDTH-1:0] DEFAULT_SEED  = 16'hACE1,
    parameter int unsigned      STEPS_PER_OUT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
`ifdef RNG_PERIOD_FLAG_EN
    output logic             period_wrap,
`endif
    random_lfsr_stream_if.master stream
);
    import random_pkg::*;

    localparam int unsigned     CntW    = $clog2(STEPS_PER_OUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(STEPS_PER_OUT - 1);

    rng_state_t       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] eff_seed;
    logic [WIDTH-1:0] lfsr_next;
    logic             adv;

    // An all-zero seed would lock the LFSR, so substitute the default
    assign eff_seed = (seed == '0) ? DEFAULT_SEED : seed;

    lfsr_core #(
        .WIDTH        (WIDTH),
        .TAPS         (TAPS),
        .DEFAULT_SEED (DEFAULT_SEED)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (seed_load),
        .load_val (eff_seed),
        .adv      (adv),
        .step_val (lfsr_next)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        data_d  = data_q;
        adv     = 1'b0;
        if (seed_load) begin
            // Any pending word is dropped, even if the consumer is ready this cycle
            cnt_d   = '0;
            valid_d = 1'b0;
            state_d = StFill;
        end else begin
            unique case (state_q)
                StFill: begin
                    adv   = 1'b1;
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntLast) begin
                        data_d  = lfsr_next;
                        valid_d = 1'b1;
                        state_d = StValid;
                    end
                end
                StValid: begin
                    if (stream.out_ready) begin
                        adv = 1'b1;
                        if (STEPS_PER_OUT == 1) begin
                            data_d = lfsr_next;
                        end else begin
                            // The handshake cycle already counts as the first shift
                            cnt_d   = CntW'(1);
                            valid_d = 1'b0;
                            state_d = StFill;
                        end
                    end
                end
                default: state_d = StFill;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFill;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign stream.out_valid = valid_q;
    assign stream.out_data  = data_q;

`ifdef RNG_PERIOD_FLAG_EN
    logic [WIDTH-1:0] ref_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_q <= DEFAULT_SEED;
        end else if (seed_load) begin
            ref_q <= eff_seed;
        end
    end

    assign period_wrap = valid_q && (data_q == ref_q);
`endif

endmodule

// File: tb/tb_random_lfsr_stream.sv
// Self-checking bench for random_lfsr_stream: vector table, corner sequences and a
// randomized run against a word-level reference model (two DUTs: 1 and 4 steps per word).
module tb_random_lfsr_stream;

    localparam logic [15:0] TAPS  = 16'hB400;
    localparam logic [15:0] DSEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld1, ld4;
    logic [15:0] sd1, sd4;
`ifdef RNG_PERIOD_FLAG_EN
    logic        pw1, pw4;
`endif

    int unsigned n_pass = 0;
    int unsigned n_tot  = 0;

    random_lfsr_stream_if #(.WIDTH(16)) s1 ();
    random_lfsr_stream_if #(.WIDTH(16)) s4 ();

    always #5 clk = ~clk;

    random_lfsr_stream #(
        .WIDTH(16), .TAPS(TAPS), .DEFAULT_SEED(DSEED), .STEPS_PER_OUT(1)
    ) dut1 (
        .clk(clk), .rst(rst), .seed_load(ld1), .seed(sd1),
`ifdef RNG_PERIOD_FLAG_EN
        .period_wrap(pw1),
`endif
        .stream(s1)
    );

    random_lfsr_stream #(
        .WIDTH(16), .TAPS(TAPS), .DEFAULT_SEED(DSEED), .STEPS_PER_OUT(4)
    ) dut4 (
        .clk(clk), .rst(rst), .seed_load(ld4), .seed(sd4),
`ifdef RNG_PERIOD_FLAG_EN
        .period_wrap(pw4),
`endif
        .stream(s4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [15:0] step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : 16'h0);
    endfunction

    function automatic logic [15:0] stepn(input logic [15:0] s, input int n);
        logic [15:0] x = s;
        for (int k = 0; k < n; k++) x = step(x);
        return x;
    endfunction

    // Word-level model: next word to appear, and cycles remaining before it appears
    typedef struct {
        bit          v;
        logic [15:0] d;
        logic [15:0] nxt;
        int          rem;
    } mdl_t;

    function automatic mdl_t mdl_edge(input mdl_t m, input int s, input bit r, input bit l,
                                      input logic [15:0] sd, input bit rdy);
        mdl_t n = m;
        if (r) begin
            n.v = 0; n.d = 16'h0; n.nxt = stepn(DSEED, s); n.rem = s;
        end else if (l) begin
            n.v = 0; n.nxt = stepn((sd == 16'h0) ? DSEED : sd, s); n.rem = s;
        end else if (m.v) begin
            if (rdy) begin
                if (s == 1) n.d = step(m.d);
                else begin n.v = 0; n.nxt = stepn(m.d, s); n.rem = s - 1; end
            end
        end else begin
            n.rem = m.rem - 1;
            if (n.rem == 0) begin n.v = 1; n.d = m.nxt; end
        end
        return n;
    endfunction

    typedef struct {
        bit          r;
        bit          l;
        logic [15:0] sd;
        bit          rdy;
        bit          ev;
        bit          cd;
        logic [15:0] ed;
    } vec_t;

    vec_t tbl[14];

    initial begin
        mdl_t        m1, m4;
        bit          r, l1, l4, y1, y4;
        logic [15:0] w;

        tbl[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000};
        tbl[1]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000};
        tbl[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'hE270};
        tbl[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h7138};
        tbl[4]  = '{1'b0, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[5]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'hB400};
        tbl[6]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h5A00};
        tbl[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h2D00};
        tbl[8]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h2D00};
        tbl[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h2D00};
        tbl[10] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h1680};
        tbl[11] = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[12] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'hE270};
        tbl[13] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h7138};

        rst = 1'b1; ld1 = 1'b0; ld4 = 1'b0; sd1 = 16'h0; sd4 = 16'h0;
        s1.out_ready = 1'b0; s4.out_ready = 1'b0;

        // Vector table on the one-step DUT
        @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            rst = tbl[i].r; ld1 = tbl[i].l; sd1 = tbl[i].sd; s1.out_ready = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("tbl%0d_valid", i), 32'(s1.out_valid), 32'(tbl[i].ev));
            if (tbl[i].cd) chk($sformatf("tbl%0d_data", i), 32'(s1.out_data), 32'(tbl[i].ed));
        end

        // Back-pressure: ten stalled cycles, then resume with the very next word
        ld1 = 1'b0; s1.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_valid", i), 32'(s1.out_valid), 32'd1);
            chk($sformatf("stall%0d_data", i), 32'(s1.out_data), 32'h7138);
        end
        s1.out_ready = 1'b1;
        @(negedge clk);
        chk("resume_data", 32'(s1.out_data), 32'(step(16'h7138)));

        // Four steps per word: load seed 1, word after four fill cycles, then every four
        ld4 = 1'b1; sd4 = 16'h0001; s4.out_ready = 1'b1;
        @(negedge clk);
        ld4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("s4_fill%0d_valid", i), 32'(s4.out_valid), 32'd0);
            @(negedge clk);
        end
        chk("s4_first_valid", 32'(s4.out_valid), 32'd1);
        chk("s4_first_data", 32'(s4.out_data), 32'(stepn(16'h0001, 4)));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("s4_gap%0d_valid", i), 32'(s4.out_valid), 32'd0);
        end
        @(negedge clk);
        chk("s4_second_valid", 32'(s4.out_valid), 32'd1);
        chk("s4_second_data", 32'(s4.out_data), 32'(stepn(16'h0001, 8)));
        s4.out_ready = 1'b0;

`ifdef RNG_PERIOD_FLAG_EN
        // Full period from seed 1: flag on word 65535 only, then reset mid-stream
        ld1 = 1'b1; sd1 = 16'h0001; s1.out_ready = 1'b1;
        @(negedge clk);
        ld1 = 1'b0;
        chk("per_load_valid", 32'(s1.out_valid), 32'd0);
        for (int k = 1; k <= 65537; k++) begin
            @(negedge clk);
            chk($sformatf("per_wrap_w%0d", k), 32'(pw1), 32'(k == 65535));
            if (k == 1 || k == 65535)
                chk($sformatf("per_data_w%0d", k), 32'(s1.out_data), 32'(stepn(16'h0001, k)));
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("per_rst_valid", 32'(s1.out_valid), 32'd0);
        chk("per_rst_wrap", 32'(pw1), 32'd0);
        @(negedge clk);
        chk("per_restart_data", 32'(s1.out_data), 32'hE270);
`endif

        // Randomized run of both DUTs against the word-level model
        rst = 1'b1; ld1 = 1'b0; ld4 = 1'b0; s1.out_ready = 1'b0; s4.out_ready = 1'b0;
        m1 = '{1'b0, 16'h0, 16'h0, 0};
        m4 = '{1'b0, 16'h0, 16'h0, 0};
        m1 = mdl_edge(m1, 1, 1'b1, 1'b0, 16'h0, 1'b0);
        m4 = mdl_edge(m4, 4, 1'b1, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            chk($sformatf("rnd%0d_v1", i), 32'(s1.out_valid), 32'(m1.v));
            chk($sformatf("rnd%0d_v4", i), 32'(s4.out_valid), 32'(m4.v));
            if (m1.v) chk($sformatf("rnd%0d_d1", i), 32'(s1.out_data), 32'(m1.d));
            if (m4.v) chk($sformatf("rnd%0d_d4", i), 32'(s4.out_data), 32'(m4.d));
            r  = ($urandom_range(99) == 0);
            l1 = ($urandom_range(29) == 0);
            l4 = ($urandom_range(29) == 0);
            y1 = ($urandom_range(3) != 0);
            y4 = ($urandom_range(3) != 0);
            w = 16'($urandom);
            sd1 = ($urandom_range(3) == 0) ? 16'h0 : w;
            w = 16'($urandom);
            sd4 = ($urandom_range(3) == 0) ? 16'h0 : w;
            rst = r; ld1 = l1; ld4 = l4; s1.out_ready = y1; s4.out_ready = y4;
            m1 = mdl_edge(m1, 1, r, l1, sd1, y1);
            m4 = mdl_edge(m4, 4, r, l4, sd4, y4);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
